// File: rtl/seq_rom.sv
// seq_rom: small lookup table with a one-entry output register, serving
// single reads and auto-incrementing bursts over a ready/valid output.
// Entry i holds (i*STEP) mod 2^DATA_W after reset.
// Optional feature macro: SEQ_ROM_WR_EN adds a synchronous table write port.
module seq_rom #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int STEP   = 2,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SEQ_ROM_WR_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_base,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_err,
    output logic              dout_valid,
    input  logic              dout_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              slot_free;
    logic              issue;
    logic              load_burst;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_in_range;
    logic [DATA_W-1:0] table_data;

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) * 32'(STEP));
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign slot_free      = !dout_valid || dout_ready;
    assign rd_ready       = (state == IDLE) && slot_free && !burst_start;
    assign busy           = (state == BURST);
    assign issue_in_range = addr_in_range(issue_addr);

`ifdef SEQ_ROM_WR_EN
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Table storage: reload the init pattern on reset, accept in-range writes otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= init_val(ADDR_W'(i));
            end
        end else if (wr_en && addr_in_range(wr_addr)) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign table_data = mem[issue_addr[IDX_W-1:0]];
`else
    assign table_data = init_val(issue_addr);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and beat issue decision; a burst start only latches, beats follow in BURST
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        load_burst = 1'b0;
        issue_addr = '0;
        case (state)
            IDLE: begin
                if (slot_free && burst_start) begin
                    if (burst_len != '0) begin
                        load_burst = 1'b1;
                        next_state = BURST;
                    end
                end else if (slot_free && rd_valid) begin
                    issue      = 1'b1;
                    issue_addr = rd_addr;
                end
            end
            BURST: begin
                if (slot_free) begin
                    issue      = 1'b1;
                    issue_addr = cur_addr;
                    if (!addr_in_range(cur_addr) || (remaining == LEN_W'(1))) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Burst address and beat counter; the address wraps at the end of the table
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (load_burst) begin
            cur_addr  <= burst_base;
            remaining <= burst_len;
        end else if (issue && (state == BURST)) begin
            cur_addr  <= (cur_addr == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Output register: load a new beat when issued, otherwise hold until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_err   <= 1'b0;
            dout_valid <= 1'b0;
        end else if (issue) begin
            dout       <= issue_in_range ? table_data : '0;
            dout_err   <= !issue_in_range;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_rom.sv
// tb_seq_rom: directed self-checking bench for seq_rom with default parameters.
// Define SEQ_ROM_WR_EN for both files to exercise the write port.
module tb_seq_rom;

    logic       clk;
    logic       rst;
    logic       rd_valid;
    logic [7:0] rd_addr;
    logic       rd_ready;
    logic       burst_start;
    logic [7:0] burst_base;
    logic [7:0] burst_len;
    logic       busy;
    logic [3:0] dout;
    logic       dout_err;
    logic       dout_valid;
    logic       dout_ready;
`ifdef SEQ_ROM_WR_EN
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [3:0] wr_data;
`endif

    int checkCount;
    int errorCount;

    seq_rom dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ_ROM_WR_EN
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`endif
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .burst_start (burst_start),
        .burst_base  (burst_base),
        .burst_len   (burst_len),
        .busy        (busy),
        .dout        (dout),
        .dout_err    (dout_err),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full output beat in one call
    task automatic checkBeat(input string tag, input int expValid, input int expData, input int expErr);
        checkOutput({tag, ".valid"}, int'(dout_valid), expValid);
        checkOutput({tag, ".dout"},  int'(dout),       expData);
        checkOutput({tag, ".err"},   int'(dout_err),   expErr);
    endtask

    // Directed stimulus with hand-computed expectations (entry i = 2*i mod 16)
    initial begin
        int expBurst[4];
        checkCount  = 0;
        errorCount  = 0;
        rst         = 1'b1;
        rd_valid    = 1'b0;
        rd_addr     = '0;
        burst_start = 1'b0;
        burst_base  = '0;
        burst_len   = '0;
        dout_ready  = 1'b1;
`ifdef SEQ_ROM_WR_EN
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
        checkBeat("reset", 0, 0, 0);
        checkOutput("reset.busy", int'(busy), 0);

        // Single in-range read
        rd_valid = 1'b1;
        rd_addr  = 8'd5;
        #1;
        checkOutput("rd5.rd_ready", int'(rd_ready), 1);
        tick();
        rd_valid = 1'b0;
        checkBeat("rd5", 1, 10, 0);

        // Single out-of-range read
        rd_valid = 1'b1;
        rd_addr  = 8'd9;
        tick();
        rd_valid = 1'b0;
        checkBeat("rd9", 1, 0, 1);
        tick();
        checkOutput("rd9.drain", int'(dout_valid), 0);

        // Burst with wrap, consumer always ready
        expBurst = '{12, 14, 0, 2};
        burst_start = 1'b1;
        burst_base  = 8'd6;
        burst_len   = 8'd4;
        tick();
        burst_start = 1'b0;
        checkOutput("b6.busy_start", int'(busy), 1);
        checkOutput("b6.no_beat_yet", int'(dout_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkBeat($sformatf("b6.beat%0d", i), 1, expBurst[i], 0);
            checkOutput($sformatf("b6.busy%0d", i), int'(busy), (i == 3) ? 0 : 1);
        end
        tick();
        checkOutput("b6.drain", int'(dout_valid), 0);

        // Burst with back-pressure after the first beat
        burst_start = 1'b1;
        burst_base  = 8'd0;
        burst_len   = 8'd3;
        tick();
        burst_start = 1'b0;
        tick();
        checkBeat("b0.beat0", 1, 0, 0);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkBeat($sformatf("b0.hold%0d", i), 1, 0, 0);
            checkOutput($sformatf("b0.hold_busy%0d", i), int'(busy), 1);
        end
        dout_ready = 1'b1;
        tick();
        checkBeat("b0.beat1", 1, 2, 0);
        tick();
        checkBeat("b0.beat2", 1, 4, 0);
        checkOutput("b0.busy_end", int'(busy), 0);
        tick();
        checkOutput("b0.drain", int'(dout_valid), 0);

        // Zero-length burst is ignored and blocks the simultaneous read
        burst_start = 1'b1;
        burst_len   = 8'd0;
        rd_valid    = 1'b1;
        rd_addr     = 8'd1;
        #1;
        checkOutput("len0.rd_ready", int'(rd_ready), 0);
        tick();
        burst_start = 1'b0;
        rd_valid    = 1'b0;
        checkOutput("len0.busy", int'(busy), 0);
        checkOutput("len0.valid", int'(dout_valid), 0);

        // Out-of-range burst base gives one error beat
        burst_start = 1'b1;
        burst_base  = 8'd9;
        burst_len   = 8'd3;
        tick();
        burst_start = 1'b0;
        tick();
        checkBeat("b9.beat", 1, 0, 1);
        checkOutput("b9.busy", int'(busy), 0);
        tick();
        checkOutput("b9.drain", int'(dout_valid), 0);

        // Burst wins over a simultaneous read, then reset on the second beat
        burst_start = 1'b1;
        burst_base  = 8'd1;
        burst_len   = 8'd4;
        rd_valid    = 1'b1;
        rd_addr     = 8'd2;
        #1;
        checkOutput("prio.rd_ready", int'(rd_ready), 0);
        tick();
        burst_start = 1'b0;
        rd_valid    = 1'b0;
        checkOutput("prio.busy", int'(busy), 1);
        checkOutput("prio.no_read", int'(dout_valid), 0);
        tick();
        checkBeat("prio.beat0", 1, 2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkBeat("abort", 0, 0, 0);
        checkOutput("abort.busy", int'(busy), 0);
        tick();
        checkOutput("abort.quiet", int'(dout_valid), 0);

`ifdef SEQ_ROM_WR_EN
        // Write with a same-cycle read of the same address returns old data
        wr_en    = 1'b1;
        wr_addr  = 8'd3;
        wr_data  = 4'd7;
        rd_valid = 1'b1;
        rd_addr  = 8'd3;
        tick();
        wr_en    = 1'b0;
        checkBeat("wr.same_cycle", 1, 6, 0);
        tick();
        rd_valid = 1'b0;
        checkBeat("wr.readback", 1, 7, 0);
        // Out-of-range write is dropped
        wr_en   = 1'b1;
        wr_addr = 8'd11;
        wr_data = 4'd9;
        tick();
        wr_en = 1'b0;
        rst   = 1'b1;
        tick();
        rst      = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 8'd3;
        tick();
        rd_valid = 1'b0;
        checkBeat("wr.after_reset", 1, 6, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
